// File: rtl/mult_pkg.sv
// Shared definitions for the add-shift multiplier sequencer and its datapath.
package mult_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned N_REQ = 2;

    // Datapath command encodings
    localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
    localparam logic [OP_W-1:0] OP_SHIFT = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
    localparam logic [OP_W-1:0] OP_HOLD  = 3'b111;

    // Index of the multiplier MSB; that bit is subtracted rather than added
    localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SUB   = 3'd4,
        ST_SHIFT = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arb2
    import mult_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last,
    output logic [N_REQ-1:0] win_c
);

    // One-hot winner selection
    always_comb begin
        win_c = '0;
        case (req)
            2'b01:   win_c = 2'b01;
            2'b10:   win_c = 2'b10;
            2'b11:   win_c = last ? 2'b01 : 2'b10;
            default: win_c = '0;
        endcase
    end

endmodule

// File: rtl/mult_sched.sv
// Sequencer for a shared add-shift multiplier serving two requesters.
// Walks B from LSB to MSB: EVAL samples M, ADD/SUB accumulate, SHIFT advances.
module mult_sched
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             M,
    input  logic             rsp_ready,
    output logic [N_REQ-1:0] gnt,
    output logic             sel,
    output logic [OP_W-1:0]  op,
    output logic             rsp_valid,
    output logic             rsp_id
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic [N_REQ-1:0]   win_c;

    rr_arb2 u_arb (
        .req   (req),
        .last  (last),
        .win_c (win_c)
    );

    // State machine; op/gnt/rsp are registered alongside the state they belong to
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sel       <= 1'b0;
            last      <= 1'b1;
            gnt       <= '0;
            op        <= OP_HOLD;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (req != '0) begin
                        state <= ST_LOAD;
                        op    <= OP_LOAD;
                        sel   <= win_c[1];
                        gnt   <= win_c;
                    end
                end
                ST_LOAD: begin
                    state <= ST_EVAL;
                    op    <= OP_HOLD;
                    cnt   <= '0;
                    last  <= sel;
                end
                ST_EVAL: begin
                    if (!M) begin
                        state <= ST_SHIFT;
                        op    <= OP_SHIFT;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_SUB;
                        op    <= OP_SUB;
                    end else begin
                        state <= ST_ADD;
                        op    <= OP_ADD;
                    end
                end
                ST_ADD, ST_SUB: begin
                    state <= ST_SHIFT;
                    op    <= OP_SHIFT;
                end
                ST_SHIFT: begin
                    op <= OP_HOLD;
                    if (cnt == CNT_LAST) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_id    <= sel;
                    end else begin
                        state <= ST_EVAL;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    op <= OP_HOLD;
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    op        <= OP_HOLD;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched with a behavioural multiplier-LSB model.
module tb_mult_sched;
    import mult_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic       M;
    logic       rsp_ready = 1'b1;
    logic [1:0] gnt;
    logic       sel;
    logic [2:0] op;
    logic       rsp_valid;
    logic       rsp_id;

    mult_sched dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
        .M         (M),
        .rsp_ready (rsp_ready),
        .gnt       (gnt),
        .sel       (sel),
        .op        (op),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        id;
        int          lat;
        logic [31:0] add_m;
        logic [31:0] sub_m;
        int          hold;
    } exp_t;

    exp_t       rq[$];
    logic [1:0] gq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int stall_left = 0;
    bit cont = 1'b0;
    logic [7:0] b_op [2];
    logic [7:0] b_reg = 8'h00;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    function automatic exp_t mk(input logic id, input int lat, input logic [31:0] am,
                                input logic [31:0] sm, input int hold);
        exp_t e;
        e.id = id; e.lat = lat; e.add_m = am; e.sub_m = sm; e.hold = hold;
        return e;
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    // Datapath model: B register loaded on LOAD, shifted right on SHIFT
    always @(posedge Clk) begin
        if (op == OP_LOAD)       b_reg <= b_op[sel];
        else if (op == OP_SHIFT) b_reg <= b_reg >> 1;
    end
    assign M = b_reg[0];

    // Requesters drop their request once granted; consumer stalls stall_left cycles
    always @(posedge Clk) begin
        #1;
        if (!cont) req = req & ~gnt;
        if (stall_left > 0) begin
            rsp_ready = 1'b0;
            if (rsp_valid) stall_left--;
        end else begin
            rsp_ready = 1'b1;
        end
    end

    // Monitor state
    bit          active = 1'b0;
    bit          in_done = 1'b0;
    bit          no_exp = 1'b0;
    bit          hs_seen = 1'b0;
    int          g_cyc = 0;
    int          hs_cyc = 0;
    int          hold_n = 0;
    int          nev = 0;
    int          nsh = 0;
    logic        cur_id = 1'b0;
    logic [31:0] add_m = '0;
    logic [31:0] sub_m = '0;
    exp_t        cur_e;

    always @(negedge Reset_n) begin
        active  = 1'b0;
        in_done = 1'b0;
    end

    // Monitor: compare grants and responses against the scoreboard queues
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (gnt != 2'b00) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'h0);
                end else begin
                    chk("gnt", 32'(gnt), 32'(gq.pop_front()));
                end
                chk("load_op", 32'(op), 32'(OP_LOAD));
                chk("load_sel", 32'(sel), 32'(gnt[1]));
                if (hs_seen) chk("gnt_gap_ok", 32'(cyc - hs_cyc >= 2), 32'h1);
                active = 1'b1; g_cyc = cyc; cur_id = gnt[1];
                add_m = '0; sub_m = '0; nev = 0; nsh = 0;
            end else if (active && !rsp_valid) begin
                int off;
                off = cyc - g_cyc;
                if (off < 32) begin
                    if (op == OP_ADD) add_m[off[4:0]] = 1'b1;
                    if (op == OP_SUB) sub_m[off[4:0]] = 1'b1;
                end
                if (op == OP_HOLD)  nev++;
                if (op == OP_SHIFT) nsh++;
            end
            if (rsp_valid) begin
                if (!in_done) begin
                    in_done = 1'b1; hold_n = 0;
                    if (rq.size() == 0) begin
                        no_exp = 1'b1;
                        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
                    end else begin
                        no_exp = 1'b0;
                        cur_e = rq.pop_front();
                        chk("rsp_id", 32'(rsp_id), 32'(cur_e.id));
                        chk("done_latency", 32'(cyc - g_cyc), 32'(cur_e.lat));
                        chk("add_cycles", add_m, cur_e.add_m);
                        chk("sub_cycles", sub_m, cur_e.sub_m);
                        chk("eval_count", 32'(nev), 32'd8);
                        chk("shift_count", 32'(nsh), 32'd8);
                        chk("done_sel", 32'(sel), 32'(cur_id));
                    end
                end else if (!no_exp) begin
                    chk("rsp_id_hold", 32'(rsp_id), 32'(cur_e.id));
                end
                hold_n++;
                if (rsp_ready) begin
                    if (!no_exp) chk("valid_hold", 32'(hold_n), 32'(cur_e.hold));
                    in_done = 1'b0; active = 1'b0;
                    hs_cyc = cyc; hs_seen = 1'b1; hs_count++;
                end
            end
        end
    end

    task automatic wait_hs(input int target, input string nm);
        int n;
        n = 0;
        while (hs_count < target && n < 300) begin
            @(posedge Clk);
            n++;
        end
        if (hs_count < target) chk({nm, "_timeout"}, 32'(hs_count), 32'(target));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_gnt"}, 32'(gnt), 32'h0);
        chk({nm, "_op"}, 32'(op), 32'(OP_HOLD));
        chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({nm, "_rsp_id"}, 32'(rsp_id), 32'h0);
        chk({nm, "_sel"}, 32'(sel), 32'h0);
    endtask

    initial begin
        b_op[0] = 8'h00; b_op[1] = 8'h00;
        repeat (3) @(posedge Clk);
        #2;
        chk_reset_outputs("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);

        // B=0x03 from requester 0: ADDs at +2 and +5, DONE at +19
        b_op[0] = 8'h03;
        gq.push_back(2'b01); rq.push_back(mk(1'b0, 19, 32'h0000_0024, 32'h0, 1));
        @(negedge Clk); req[0] = 1'b1;
        wait_hs(1, "t1");

        // B=0x80 from requester 1: single SUB at +16, DONE at +18
        b_op[1] = 8'h80;
        gq.push_back(2'b10); rq.push_back(mk(1'b1, 18, 32'h0, 32'h0001_0000, 1));
        @(negedge Clk); req[1] = 1'b1;
        wait_hs(2, "t2");

        // B=0xFF with a 5-cycle consumer stall: DONE at +25, valid held 6 cycles
        b_op[0] = 8'hFF;
        stall_left = 5;
        gq.push_back(2'b01); rq.push_back(mk(1'b0, 25, 32'h0012_4924, 32'h0080_0000, 6));
        @(negedge Clk); req[0] = 1'b1;
        wait_hs(3, "t3");

        // B=0x00: only EVAL/SHIFT pairs, DONE at +17
        b_op[1] = 8'h00;
        gq.push_back(2'b10); rq.push_back(mk(1'b1, 17, 32'h0, 32'h0, 1));
        @(negedge Clk); req[1] = 1'b1;
        wait_hs(4, "t4");

        // Both requesting continuously: grants alternate starting with requester 0
        b_op[0] = 8'h03; b_op[1] = 8'h80;
        for (int i = 0; i < 2; i++) begin
            gq.push_back(2'b01); rq.push_back(mk(1'b0, 19, 32'h0000_0024, 32'h0, 1));
            gq.push_back(2'b10); rq.push_back(mk(1'b1, 18, 32'h0, 32'h0001_0000, 1));
        end
        @(negedge Clk); cont = 1'b1; req = 2'b11;
        wait_hs(8, "t5");
        req = 2'b00; cont = 1'b0;
        repeat (3) @(posedge Clk);

        // Reset during the ADD of bit 4: no response, outputs forced at once
        begin
            int n_add;
            int n;
            n_add = 0; n = 0;
            b_op[1] = 8'hFF;
            gq.push_back(2'b10);
            @(negedge Clk); req[1] = 1'b1;
            while (n_add < 5 && n < 100) begin
                @(posedge Clk); #2;
                if (op == OP_ADD) n_add++;
                n++;
            end
            chk("t6_reach_add4", 32'(n_add), 32'd5);
            #1 Reset_n = 1'b0;
            #1 chk_reset_outputs("midop_reset");
            repeat (2) @(posedge Clk);
            @(negedge Clk); Reset_n = 1'b1;
            repeat (3) @(posedge Clk);
            #2 chk("post_reset_op", 32'(op), 32'(OP_HOLD));
        end

        // After reset requester 0 wins the tie, then requester 1
        b_op[0] = 8'h01; b_op[1] = 8'h01;
        gq.push_back(2'b01); rq.push_back(mk(1'b0, 18, 32'h0000_0004, 32'h0, 1));
        gq.push_back(2'b10); rq.push_back(mk(1'b1, 18, 32'h0000_0004, 32'h0, 1));
        @(negedge Clk); req = 2'b11;
        wait_hs(10, "t7");
        repeat (4) @(posedge Clk);

        chk("rsp_queue_empty", 32'(rq.size()), 32'h0);
        chk("gnt_queue_empty", 32'(gq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have ports Clk (in, 1), the single clock, with all state updated on its rising edge.
REQ-002 SHALL have port Reset_n (in, 1); reset is asynchronous and active-low.
REQ-003 SHALL have port req (in, 2), one request bit per requester; bit i is held high until gnt[i].
REQ-004 SHALL have port M (in, 1), the multiplier LSB (B[0]) driven by the shared add-shift multiplier datapath.
REQ-005 SHALL have port rsp_ready (in, 1), the consumer accepting the result.
REQ-006 SHALL have port gnt (out, 2), a one-hot, one-cycle pulse marking the accepted requester.
REQ-007 SHALL have port sel (out, 1), the operand-mux select to the datapath; it is stable from LOAD through DONE.
REQ-008 SHALL have port op (out, 3), the datapath command: 000 LOAD (load A/B, clear XA), 001 SHIFT, 010 ADD, 011 SUB, 111 HOLD.
REQ-009 SHALL have ports rsp_valid (out, 1) and rsp_id (out, 1), marking that the product in the datapath belongs to requester rsp_id.

Function
REQ-010 SHALL implement the states IDLE, LOAD, EVAL, ADD, SUB, SHIFT and DONE, each driving a fixed op: IDLE/EVAL/DONE 111, LOAD 000, ADD 010, SUB 011, SHIFT 001.
REQ-011 SHALL, in IDLE with req!=0, register the winner into sel and move to LOAD; with req==0 it SHALL stay in IDLE.
REQ-012 SHALL arbitrate round-robin: with a single request, that requester wins; with both, the requester not granted last wins; after reset, requester 0 wins ties.
REQ-013 SHALL assert gnt[sel] only during the LOAD cycle; the requester holds its operands through that cycle.
REQ-014 SHALL go LOAD -> EVAL and clear the 3-bit bit counter cnt to 0.
REQ-015 SHALL, in EVAL, go to SHIFT if M=0, to SUB if M=1 and cnt==7, and otherwise to ADD; M is sampled only in EVAL.
REQ-016 SHALL go ADD -> SHIFT and SUB -> SHIFT.
REQ-017 SHALL, in SHIFT, go to DONE when cnt==7; otherwise it SHALL increment cnt and go to EVAL.
REQ-018 SHALL put the LOAD-to-DONE latency at exactly 17 + popcount(B) cycles, i.e. DONE is entered that many cycles after the gnt cycle.
REQ-019 SHALL, in DONE, assert rsp_valid with rsp_id=sel, holding both stable until rsp_ready=1; that handshake cycle moves to IDLE.
REQ-020 SHALL not grant in the handshake cycle; a pending request is granted at the earliest in the following cycle, from IDLE.
REQ-021 SHALL ignore requests that arrive while busy (LOAD..DONE); they are held by the requester and arbitrated in IDLE.
REQ-022 SHALL update the round-robin last-grant pointer only in the LOAD cycle.

Reset
REQ-023 SHALL, on Reset_n low, immediately force: state=IDLE, cnt=0, sel=0, last-grant=1, gnt=00, op=111, rsp_valid=0, rsp_id=0.
REQ-024 SHALL abandon a multiplication in progress when reset is asserted mid-operation, with no response produced; the datapath result is then undefined.
REQ-025 SHALL leave IDLE no earlier than the first rising edge after Reset_n deasserts.

Structure
REQ-026 SHALL take its op encodings (OP_LOAD, OP_SHIFT, OP_ADD, OP_SUB, OP_HOLD) and the state enum from shared package mult_pkg, which the datapath also imports.
REQ-027 SHALL place the 2-way round-robin arbiter in sub-module rr_arb2 (inputs req, last; output one-hot winner).
REQ-028 SHALL contain no datapath arithmetic; it only sequences.

Verification
REQ-029 SHALL cover: reset, then req=01 with B=0x03 -> gnt=01 at t; ADD at t+2 and t+5; SUB never; rsp_valid=1, rsp_id=0 at t+19.
REQ-030 SHALL cover: req=10 with B=0x80 -> op sequence has zero ADDs and exactly one SUB, at t+16; DONE at t+18.
REQ-031 SHALL cover: req=11 held continuously with rsp_ready=1 -> grants alternate 01,10,01,...; each gnt is at least 2 cycles after the previous rsp_valid handshake cycle.
REQ-032 SHALL cover: B=0xFF with rsp_ready=0 for 5 cycles after DONE -> 7 ADD, 1 SUB, DONE at t+25, rsp_valid held 6 cycles, rsp_id stable.
REQ-033 SHALL cover: Reset_n pulsed low during ADD of bit 4 -> outputs take REQ-023 values asynchronously, no rsp_valid, and the next req is granted normally.
REQ-034 SHALL cover: B=0x00 -> no ADD/SUB, eight EVAL/SHIFT pairs, DONE at t+17.
